voiceprint_result_reporter: RTL and testbench

//  Downstream of the voiceprint recognition top. Captures recognition_result on each

---
 rtl/voiceprint_result_reporter.sv | 171 +++++++++++++++++
 tb/tb_voiceprint_result_reporter.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/voiceprint_result_reporter.sv
// Turns recognition-result and training-done events into short ASCII messages and streams
// them byte-by-byte over a valid/ready handshake to the RS232 TX serializer.
module voiceprint_result_reporter #(
    parameter logic [2:0]  NOMATCH_CODE   = 3'd7,
    parameter int unsigned INTER_BYTE_GAP = 16,
    parameter int unsigned GAP_W          = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] recognition_result,
    input  logic       recognition_result_flag,
    input  logic       train_down,
    input  logic       tx_ready,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    output logic [2:0] last_result,
    output logic       result_valid,
    output logic       busy,
    output logic       overrun
);

    localparam bit             UseGap  = (INTER_BYTE_GAP != 0);
    localparam logic [GAP_W-1:0] GapLast = GAP_W'(INTER_BYTE_GAP - 1);

    typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

    state_e           state_q, state_d;
    logic             res_flag_q, trn_flag_q;
    logic             res_rise, trn_rise;
    logic             res_pend_q, res_pend_d;
    logic             trn_pend_q, trn_pend_d;
    logic             res_take, trn_take;
    logic [2:0]       res_buf_q;
    logic [2:0]       last_result_q;
    logic             result_valid_q;
    logic             overrun_q;
    logic             msg_trn_q, msg_trn_d;
    logic [7:0]       msg_digit_q, msg_digit_d;
    logic [2:0]       idx_q, idx_d;
    logic [2:0]       last_idx;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             done_q, done_d;

    assign res_rise = recognition_result_flag & ~res_flag_q;
    assign trn_rise = train_down & ~trn_flag_q;
    assign last_idx = msg_trn_q ? 3'd4 : 3'd5;

    // A rise in the same cycle as the FSM takes the pending bit keeps it set for the next message.
    assign res_pend_d = res_rise | (res_pend_q & ~res_take);
    assign trn_pend_d = trn_rise | (trn_pend_q & ~trn_take);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        gap_cnt_d   = gap_cnt_q;
        done_d      = done_q;
        msg_trn_d   = msg_trn_q;
        msg_digit_d = msg_digit_q;
        res_take    = 1'b0;
        trn_take    = 1'b0;
        tx_valid    = 1'b0;
        case (state_q)
            StIdle: begin
                if (res_pend_q) begin
                    res_take    = 1'b1;
                    msg_trn_d   = 1'b0;
                    msg_digit_d = (res_buf_q == NOMATCH_CODE) ? 8'h3F
                                                              : 8'h30 + {5'd0, res_buf_q};
                    idx_d       = 3'd0;
                    done_d      = 1'b0;
                    state_d     = StSend;
                end else if (trn_pend_q) begin
                    trn_take  = 1'b1;
                    msg_trn_d = 1'b1;
                    idx_d     = 3'd0;
                    done_d    = 1'b0;
                    state_d   = StSend;
                end
            end
            StSend: begin
                tx_valid = 1'b1;
                if (tx_ready) begin
                    gap_cnt_d = '0;
                    if (idx_q == last_idx) begin
                        done_d  = 1'b1;
                        state_d = UseGap ? StGap : StIdle;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = UseGap ? StGap : StSend;
                    end
                end
            end
            StGap: begin
                if (gap_cnt_q == GapLast) begin
                    state_d = done_q ? StIdle : StSend;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        tx_data = 8'h00;
        if (state_q == StSend) begin
            if (msg_trn_q) begin
                case (idx_q)
                    3'd0:    tx_data = 8'h54;
                    3'd1:    tx_data = 8'h52;
                    3'd2:    tx_data = 8'h4E;
                    3'd3:    tx_data = 8'h0D;
                    3'd4:    tx_data = 8'h0A;
                    default: tx_data = 8'h00;
                endcase
            end else begin
                case (idx_q)
                    3'd0:    tx_data = 8'h49;
                    3'd1:    tx_data = 8'h44;
                    3'd2:    tx_data = 8'h3A;
                    3'd3:    tx_data = msg_digit_q;
                    3'd4:    tx_data = 8'h0D;
                    3'd5:    tx_data = 8'h0A;
                    default: tx_data = 8'h00;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            res_flag_q     <= 1'b0;
            trn_flag_q     <= 1'b0;
            res_pend_q     <= 1'b0;
            trn_pend_q     <= 1'b0;
            res_buf_q      <= 3'd0;
            last_result_q  <= 3'd0;
            result_valid_q <= 1'b0;
            overrun_q      <= 1'b0;
            msg_trn_q      <= 1'b0;
            msg_digit_q    <= 8'h00;
            idx_q          <= 3'd0;
            gap_cnt_q      <= '0;
            done_q         <= 1'b0;
        end else begin
            state_q     <= state_d;
            res_flag_q  <= recognition_result_flag;
            trn_flag_q  <= train_down;
            res_pend_q  <= res_pend_d;
            trn_pend_q  <= trn_pend_d;
            msg_trn_q   <= msg_trn_d;
            msg_digit_q <= msg_digit_d;
            idx_q       <= idx_d;
            gap_cnt_q   <= gap_cnt_d;
            done_q      <= done_d;
            if (res_rise) begin
                res_buf_q      <= recognition_result;
                last_result_q  <= recognition_result;
                result_valid_q <= 1'b1;
            end
            overrun_q <= overrun_q | (res_rise & res_pend_q) | (trn_rise & trn_pend_q);
        end
    end

    assign last_result  = last_result_q;
    assign result_valid = result_valid_q;
    assign overrun      = overrun_q;
    assign busy         = (state_q != StIdle) | res_pend_q | trn_pend_q;

endmodule

// File: tb/tb_voiceprint_result_reporter.sv
// Scoreboard bench: two reporters (no gap / 16-cycle gap) share stimulus; a message-level
// model predicts the byte stream and status, and per-instance monitors compare.
module tb_voiceprint_result_reporter;

    localparam logic [2:0] NOMATCH = 3'd7;

    typedef struct {
        logic [7:0] b;
        bit         first;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] rec_res = 3'd0;
    logic       rec_flag = 1'b0;
    logic       trn = 1'b0;
    logic       tx_ready = 1'b0;

    logic       tx_valid [2];
    logic [7:0] tx_data  [2];
    logic [2:0] last_res [2];
    logic       res_vld  [2];
    logic       busy     [2];
    logic       ovr      [2];

    int tests_run = 0;
    int fails = 0;
    int ready_mode = 0;

    // Model state, one slot per instance
    bit         m_pr  [2] = '{0, 0};
    bit         m_pt  [2] = '{0, 0};
    logic [2:0] m_buf [2] = '{0, 0};
    bit         m_send[2] = '{0, 0};
    bit         m_gap [2] = '{0, 0};
    int         m_rem [2] = '{0, 0};
    int         m_gcnt[2] = '{0, 0};
    logic [2:0] m_last[2] = '{0, 0};
    bit         m_rv  [2] = '{0, 0};
    bit         m_ovr [2] = '{0, 0};
    bit         prev_r = 0;
    bit         prev_t = 0;
    exp_t       q0[$];
    exp_t       q1[$];
    int         low_cnt[2] = '{0, 0};
    int         acc_cnt[2] = '{0, 0};

    voiceprint_result_reporter #(
        .NOMATCH_CODE  (NOMATCH),
        .INTER_BYTE_GAP(0),
        .GAP_W         (8)
    ) dut0 (
        .clk                    (clk),
        .rst                    (rst),
        .recognition_result     (rec_res),
        .recognition_result_flag(rec_flag),
        .train_down             (trn),
        .tx_ready               (tx_ready),
        .tx_valid               (tx_valid[0]),
        .tx_data                (tx_data[0]),
        .last_result            (last_res[0]),
        .result_valid           (res_vld[0]),
        .busy                   (busy[0]),
        .overrun                (ovr[0])
    );

    voiceprint_result_reporter #(
        .NOMATCH_CODE  (NOMATCH),
        .INTER_BYTE_GAP(16),
        .GAP_W         (8)
    ) dut1 (
        .clk                    (clk),
        .rst                    (rst),
        .recognition_result     (rec_res),
        .recognition_result_flag(rec_flag),
        .train_down             (trn),
        .tx_ready               (tx_ready),
        .tx_valid               (tx_valid[1]),
        .tx_data                (tx_data[1]),
        .last_result            (last_res[1]),
        .result_valid           (res_vld[1]),
        .busy                   (busy[1]),
        .overrun                (ovr[1])
    );

    always #5 clk = ~clk;

    function automatic int gap_of(input int d);
        return (d == 0) ? 0 : 16;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Queue a whole message for instance d and mark the sender busy with it.
    task automatic start_msg(input int d, input bit is_trn, input logic [2:0] v);
        logic [7:0] b [6];
        int n;
        if (is_trn) begin
            b = '{"T", "R", "N", 8'h0D, 8'h0A, 8'h00};
            n = 5;
        end else begin
            b = '{"I", "D", ":", (v == NOMATCH) ? "?" : 8'("0" + 8'(v)), 8'h0D, 8'h0A};
            n = 6;
        end
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.b = b[i];
            e.first = (i == 0);
            if (d == 0) q0.push_back(e);
            else q1.push_back(e);
        end
        m_send[d] = 1;
        m_gap[d]  = 0;
        m_rem[d]  = n;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_r = 0;
            prev_t = 0;
            q0.delete();
            q1.delete();
            for (int d = 0; d < 2; d++) begin
                m_pr[d] = 0; m_pt[d] = 0; m_buf[d] = 0; m_send[d] = 0; m_gap[d] = 0;
                m_rem[d] = 0; m_gcnt[d] = 0; m_last[d] = 0; m_rv[d] = 0; m_ovr[d] = 0;
            end
        end else begin
            bit rr, rt;
            rr = rec_flag & ~prev_r;
            rt = trn & ~prev_t;
            prev_r = rec_flag;
            prev_t = trn;
            for (int d = 0; d < 2; d++) begin
                bit old_pr, old_pt;
                old_pr = m_pr[d];
                old_pt = m_pt[d];
                if (!m_send[d]) begin
                    if (m_pr[d]) begin
                        start_msg(d, 1'b0, m_buf[d]);
                        m_pr[d] = 0;
                    end else if (m_pt[d]) begin
                        start_msg(d, 1'b1, 3'd0);
                        m_pt[d] = 0;
                    end
                end else if (m_gap[d]) begin
                    m_gcnt[d]--;
                    if (m_gcnt[d] == 0) begin
                        m_gap[d] = 0;
                        if (m_rem[d] == 0) m_send[d] = 0;
                    end
                end else if (tx_ready) begin
                    m_rem[d]--;
                    if (gap_of(d) == 0) begin
                        if (m_rem[d] == 0) m_send[d] = 0;
                    end else begin
                        m_gap[d]  = 1;
                        m_gcnt[d] = gap_of(d);
                    end
                end
                if (rr) begin
                    if (old_pr) m_ovr[d] = 1;
                    m_pr[d] = 1; m_buf[d] = rec_res; m_last[d] = rec_res; m_rv[d] = 1;
                end
                if (rt) begin
                    if (old_pt) m_ovr[d] = 1;
                    m_pt[d] = 1;
                end
            end
        end
    end

    task automatic monitor(input int d);
        exp_t h;
        bit have;
        if (rst) begin
            low_cnt[d] = 0;
            return;
        end
        have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
        if (have) h = (d == 0) ? q0[0] : q1[0];
        check($sformatf("d%0d tx_valid", d), 32'(tx_valid[d]), 32'(m_send[d] & ~m_gap[d]));
        check($sformatf("d%0d busy", d), 32'(busy[d]), 32'(m_send[d] | m_pr[d] | m_pt[d]));
        check($sformatf("d%0d last_result", d), 32'(last_res[d]), 32'(m_last[d]));
        check($sformatf("d%0d result_valid", d), 32'(res_vld[d]), 32'(m_rv[d]));
        check($sformatf("d%0d overrun", d), 32'(ovr[d]), 32'(m_ovr[d]));
        if (tx_valid[d] === 1'b1) begin
            if (!have) check($sformatf("d%0d unexpected_byte", d), 32'(tx_data[d]), 32'hFFFF);
            else check($sformatf("d%0d tx_data", d), 32'(tx_data[d]), 32'(h.b));
            if (tx_ready) begin
                if (have) begin
                    if (!h.first) check($sformatf("d%0d gap_len", d), low_cnt[d], gap_of(d));
                    if (d == 0) void'(q0.pop_front());
                    else void'(q1.pop_front());
                end
                low_cnt[d] = 0;
                acc_cnt[d]++;
            end
        end else begin
            low_cnt[d]++;
        end
    endtask

    always @(negedge clk) begin
        monitor(0);
        monitor(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ready();
        case (ready_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = ~tx_ready;
            default: tx_ready = ($urandom_range(0, 3) != 0);
        endcase
    endtask

    function automatic bit model_idle();
        return !(m_send[0] | m_pr[0] | m_pt[0] | m_send[1] | m_pr[1] | m_pt[1]);
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        while (!model_idle() && n < 3000) begin
            drive_ready();
            tick();
            n++;
        end
        if (n >= 3000) check("drain_timeout", 32'(n), 32'd0);
        tx_ready = 1'b1;
        repeat (3) tick();
    endtask

    task automatic pulse_res(input logic [2:0] v);
        rec_res  = v;
        rec_flag = 1'b1;
        tick();
        rec_flag = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s d%0d rst tx_valid", tag, d), 32'(tx_valid[d]), 0);
            check($sformatf("%s d%0d rst tx_data", tag, d), 32'(tx_data[d]), 0);
            check($sformatf("%s d%0d rst last_result", tag, d), 32'(last_res[d]), 0);
            check($sformatf("%s d%0d rst result_valid", tag, d), 32'(res_vld[d]), 0);
            check($sformatf("%s d%0d rst busy", tag, d), 32'(busy[d]), 0);
            check($sformatf("%s d%0d rst overrun", tag, d), 32'(ovr[d]), 0);
        end
    endtask

    initial begin
        int base0, base1, n;
        repeat (2) tick();
        check_reset_state("init");
        rst = 1'b0;
        tick();

        // 1: single result, no back-pressure
        ready_mode = 0;
        tx_ready = 1'b1;
        pulse_res(3'd3);
        check("t1 tx_valid_one_after", 32'(tx_valid[0]), 0);
        tick();
        check("t1 tx_valid_two_after", 32'(tx_valid[0]), 1);
        wait_idle();
        check("t1 last_result", 32'(last_res[0]), 3);

        // 2: no-match code with alternating ready
        ready_mode = 1;
        pulse_res(NOMATCH);
        wait_idle();

        // 3: result and training finish together
        ready_mode = 0;
        rec_res = 3'd2; rec_flag = 1'b1; trn = 1'b1;
        tick();
        rec_flag = 1'b0; trn = 1'b0;
        wait_idle();

        // 4: results arriving while a message is in flight
        pulse_res(3'd1);
        tick();
        pulse_res(3'd4);
        tick();
        pulse_res(3'd5);
        wait_idle();
        check("t4 overrun", 32'(ovr[0]), 1);
        check("t4 last_result", 32'(last_res[0]), 5);

        // 5: flag held high is one event
        base0 = acc_cnt[0];
        base1 = acc_cnt[1];
        rec_res = 3'd6;
        rec_flag = 1'b1;
        repeat (100) tick();
        rec_flag = 1'b0;
        wait_idle();
        check("t5 d0 byte_count", acc_cnt[0] - base0, 6);
        check("t5 d1 byte_count", acc_cnt[1] - base1, 6);

        // 6: reset after the third byte of the slow instance
        base1 = acc_cnt[1];
        pulse_res(3'd0);
        n = 0;
        while (acc_cnt[1] < base1 + 3 && n < 500) begin
            tick();
            n++;
        end
        check("t6 wait_third_byte", 32'(acc_cnt[1] - base1), 3);
        rst = 1'b1;
        tick();
        check_reset_state("t6");
        rst = 1'b0;
        base1 = acc_cnt[1];
        repeat (40) tick();
        check("t6 no_bytes_after_reset", 32'(acc_cnt[1] - base1), 0);
        base0 = acc_cnt[0];
        pulse_res(3'd5);
        wait_idle();
        check("t6 d0 byte_count", acc_cnt[0] - base0, 6);
        check("t6 d1 byte_count", acc_cnt[1] - base1, 6);

        // Random traffic with random back-pressure
        ready_mode = 2;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) rec_flag = ~rec_flag;
            if ($urandom_range(0, 11) == 0) trn = ~trn;
            rec_res = 3'($urandom_range(0, 7));
            drive_ready();
            tick();
        end
        rec_flag = 1'b0;
        trn = 1'b0;
        wait_idle();
        check("end q0_empty", q0.size(), 0);
        check("end q1_empty", q1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
